// File: rtl/board_click_ctl.sv
// board_click_ctl: turns left-clicks on a 12x12 player grid into board_mem writes.
// After reset it sweeps the whole board to EMPTY. Each accepted click inside the grid
// then toggles one cell between EMPTY and SHIP. A shadow occupancy map and a ship
// counter enforce a cap on the number of SHIP cells.
module board_click_ctl #(
    parameter int X_POS          = 100,
    parameter int Y_POS          = 200,
    parameter int CELL_SIZE      = 32,
    parameter int X_SIZE         = 12,
    parameter int Y_SIZE         = 12,
    parameter int MAX_SHIP_CELLS = 20
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        enable,
    input  logic [11:0] mouse_x_pos,
    input  logic [11:0] mouse_y_pos,
    input  logic        mouse_left,
    output logic [7:0]  board_write_addr,
    output logic [1:0]  board_write_data,
    output logic        board_write_enable,
    output logic [7:0]  ship_count,
    output logic        busy,
    output logic        reject
);

    localparam logic [11:0] X_LO     = 12'(X_POS);
    localparam logic [11:0] X_HI     = 12'(X_POS + X_SIZE * CELL_SIZE - 1);
    localparam logic [11:0] Y_LO     = 12'(Y_POS);
    localparam logic [11:0] Y_HI     = 12'(Y_POS + Y_SIZE * CELL_SIZE - 1);
    localparam logic [11:0] CS       = 12'(CELL_SIZE);
    localparam logic [3:0]  LAST_COL = 4'(X_SIZE - 1);
    localparam logic [3:0]  LAST_ROW = 4'(Y_SIZE - 1);
    localparam logic [7:0]  CAP      = 8'(MAX_SHIP_CELLS);

    typedef enum logic [1:0] {CLEAR, IDLE, DIV, WRITE} state_t;

    state_t            state;
    logic              mouse_sync_p0;
    logic              mouse_sync_p1;
    logic              mouse_sync_p2;
    logic              click;
    logic              in_grid;
    logic              cur_bit;
    logic [11:0]       dx;
    logic [11:0]       dy;
    logic [3:0]        row;
    logic [3:0]        col;
    logic [X_SIZE-1:0] shadow [Y_SIZE];

    // Saturating step of the ship counter: clamps at the cap going up and at zero going down.
    function automatic logic [7:0] count_step(input logic [7:0] cnt, input logic up);
        if (up)
            return (cnt >= CAP) ? CAP : cnt + 8'd1;
        else
            return (cnt == 8'd0) ? 8'd0 : cnt - 8'd1;
    endfunction

    // Two-flop synchronizer for the mouse_clk-domain button, plus one flop of history for edge detect.
    always_ff @(posedge clk) begin
        if (rst) begin
            mouse_sync_p0 <= 1'b0;
            mouse_sync_p1 <= 1'b0;
            mouse_sync_p2 <= 1'b0;
        end else begin
            mouse_sync_p0 <= mouse_left;
            mouse_sync_p1 <= mouse_sync_p0;
            mouse_sync_p2 <= mouse_sync_p1;
        end
    end

    // A click is the synchronized rising edge; the history flop always advances, so edges
    // arriving while the FSM is busy are simply lost.
    assign click   = mouse_sync_p1 & ~mouse_sync_p2;
    assign in_grid = (mouse_x_pos >= X_LO) && (mouse_x_pos <= X_HI) &&
                     (mouse_y_pos >= Y_LO) && (mouse_y_pos <= Y_HI);
    assign cur_bit = shadow[row][col];
    assign busy    = (state != IDLE);

    // Control FSM: CLEAR sweep, click capture, divide-by-subtraction, and the toggle write.
    always_ff @(posedge clk) begin
        if (rst) begin
            state              <= CLEAR;
            row                <= 4'd0;
            col                <= 4'd0;
            dx                 <= 12'd0;
            dy                 <= 12'd0;
            board_write_enable <= 1'b0;
            board_write_addr   <= 8'd0;
            board_write_data   <= 2'b00;
            ship_count         <= 8'd0;
            reject             <= 1'b0;
            for (int r = 0; r < Y_SIZE; r++)
                shadow[r] <= '0;
        end else begin
            board_write_enable <= 1'b0;
            reject             <= 1'b0;
            case (state)
                CLEAR: begin
                    board_write_enable <= 1'b1;
                    board_write_addr   <= {row, col};
                    board_write_data   <= 2'b00;
                    if (col == LAST_COL) begin
                        col <= 4'd0;
                        if (row == LAST_ROW) begin
                            row   <= 4'd0;
                            state <= IDLE;
                        end else begin
                            row <= row + 4'd1;
                        end
                    end else begin
                        col <= col + 4'd1;
                    end
                end
                IDLE: begin
                    if (click && enable) begin
                        dx  <= mouse_x_pos - X_LO;
                        dy  <= mouse_y_pos - Y_LO;
                        row <= 4'd0;
                        col <= 4'd0;
                        if (in_grid)
                            state <= DIV;
                    end
                end
                DIV: begin
                    // x and y quotients are formed in parallel; the longer one sets the time.
                    if (dx >= CS) begin
                        dx  <= dx - CS;
                        col <= col + 4'd1;
                    end
                    if (dy >= CS) begin
                        dy  <= dy - CS;
                        row <= row + 4'd1;
                    end
                    if ((dx < CS) && (dy < CS))
                        state <= WRITE;
                end
                WRITE: begin
                    if (!cur_bit && (ship_count == CAP)) begin
                        reject <= 1'b1;
                    end else begin
                        board_write_enable <= 1'b1;
                        board_write_addr   <= {row, col};
                        board_write_data   <= {1'b0, ~cur_bit};
                        shadow[row][col]   <= ~cur_bit;
                        ship_count         <= count_step(ship_count, ~cur_bit);
                    end
                    state <= IDLE;
                end
                default: state <= CLEAR;
            endcase
        end
    end

endmodule

// File: tb/tb_board_click_ctl.sv
// Bench for board_click_ctl: directed clicks plus randomized clicks against a cell-level model.
module tb_board_click_ctl;

    localparam int X_POS     = 100;
    localparam int Y_POS     = 200;
    localparam int CELL_SIZE = 32;
    localparam int X_SIZE    = 12;
    localparam int Y_SIZE    = 12;
    localparam int TB_MAX    = 2;

    logic        clk;
    logic        rst;
    logic        enable;
    logic [11:0] mouse_x_pos;
    logic [11:0] mouse_y_pos;
    logic        mouse_left;
    logic [7:0]  board_write_addr;
    logic [1:0]  board_write_data;
    logic        board_write_enable;
    logic [7:0]  ship_count;
    logic        busy;
    logic        reject;

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model: cell occupancy, ship total, last written address/data.
    bit         shadow_m [Y_SIZE][X_SIZE];
    int         cnt_m;
    logic [7:0] last_addr_m;
    logic [1:0] last_data_m;

    board_click_ctl #(
        .X_POS(X_POS), .Y_POS(Y_POS), .CELL_SIZE(CELL_SIZE),
        .X_SIZE(X_SIZE), .Y_SIZE(Y_SIZE), .MAX_SHIP_CELLS(TB_MAX)
    ) dut (
        .clk(clk), .rst(rst), .enable(enable),
        .mouse_x_pos(mouse_x_pos), .mouse_y_pos(mouse_y_pos), .mouse_left(mouse_left),
        .board_write_addr(board_write_addr), .board_write_data(board_write_data),
        .board_write_enable(board_write_enable), .ship_count(ship_count),
        .busy(busy), .reject(reject)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        for (int r = 0; r < Y_SIZE; r++)
            for (int c = 0; c < X_SIZE; c++)
                shadow_m[r][c] = 1'b0;
        cnt_m       = 0;
        last_addr_m = 8'hBB;
        last_data_m = 2'b00;
    endtask

    // Call right after rst is released on a negedge: expects the full 144-cell sweep.
    task automatic check_clear(input string tag);
        int n_wr;
        int idle_k;
        int r;
        int c;
        n_wr   = 0;
        idle_k = -1;
        for (int k = 1; k <= 200; k++) begin
            @(negedge clk);
            if (board_write_enable) begin
                r = n_wr / X_SIZE;
                c = n_wr % X_SIZE;
                if (n_wr < 144) begin
                    chk({tag, "_addr"}, 32'(board_write_addr), 32'(r * 16 + c));
                end
                if (board_write_data !== 2'b00)
                    chk({tag, "_data"}, 32'(board_write_data), 32'd0);
                n_wr++;
            end
            if (!busy) begin
                idle_k = k;
                break;
            end
        end
        chk({tag, "_nwrites"}, 32'(n_wr), 32'd144);
        chk({tag, "_busy_len"}, 32'(idle_k), 32'd144);
        chk({tag, "_count"}, 32'(ship_count), 32'd0);
        @(negedge clk);
        chk({tag, "_we_after"}, 32'(board_write_enable), 32'd0);
        model_reset();
    endtask

    // Drives one press of `hold` cycles and checks the outcome and its exact timing.
    task automatic click(input string tag, input int x, input int y, input bit en,
                         input bit drop_en, input int hold);
        bit  in_g;
        bit  hit;
        bit  cur;
        bit  rej;
        int  col;
        int  row;
        int  lat;
        int  win;
        int  n_we;
        int  n_rej;
        int  k_we;
        int  k_rej;
        bit  busy_k3;
        logic [7:0] a_we;
        logic [1:0] d_we;

        in_g = (x >= X_POS) && (x <= X_POS + X_SIZE * CELL_SIZE - 1) &&
               (y >= Y_POS) && (y <= Y_POS + Y_SIZE * CELL_SIZE - 1);
        hit  = en && in_g;
        col  = in_g ? (x - X_POS) / CELL_SIZE : 0;
        row  = in_g ? (y - Y_POS) / CELL_SIZE : 0;
        lat  = ((col > row) ? col : row) + 1 + 4;
        cur  = shadow_m[row][col];
        rej  = hit && !cur && (cnt_m == TB_MAX);
        win  = ((lat > hold) ? lat : hold) + 4;

        n_we = 0; n_rej = 0; k_we = -1; k_rej = -1; busy_k3 = 1'b0;
        a_we = 8'h00; d_we = 2'b00;

        @(negedge clk);
        enable      = en;
        mouse_x_pos = 12'(x);
        mouse_y_pos = 12'(y);
        mouse_left  = 1'b1;
        for (int k = 1; k <= win; k++) begin
            @(negedge clk);
            if (k == 3) begin
                busy_k3 = busy;
                if (drop_en) enable = 1'b0;
            end
            if (k == hold) mouse_left = 1'b0;
            if (board_write_enable) begin
                n_we++;
                k_we = k;
                a_we = board_write_addr;
                d_we = board_write_data;
            end
            if (reject) begin
                n_rej++;
                k_rej = k;
            end
        end
        enable = 1'b1;

        if (hit && !rej) begin
            chk({tag, "_nwe"}, 32'(n_we), 32'd1);
            chk({tag, "_lat"}, 32'(k_we), 32'(lat));
            chk({tag, "_addr"}, 32'(a_we), 32'(row * 16 + col));
            chk({tag, "_data"}, 32'(d_we), 32'(!cur));
            chk({tag, "_nrej"}, 32'(n_rej), 32'd0);
            chk({tag, "_busy"}, 32'(busy_k3), 32'd1);
            shadow_m[row][col] = !cur;
            cnt_m       = cur ? cnt_m - 1 : cnt_m + 1;
            last_addr_m = 8'(row * 16 + col);
            last_data_m = {1'b0, !cur};
        end else if (rej) begin
            chk({tag, "_nwe"}, 32'(n_we), 32'd0);
            chk({tag, "_nrej"}, 32'(n_rej), 32'd1);
            chk({tag, "_rej_lat"}, 32'(k_rej), 32'(lat));
        end else begin
            chk({tag, "_nwe"}, 32'(n_we), 32'd0);
            chk({tag, "_nrej"}, 32'(n_rej), 32'd0);
        end
        chk({tag, "_count"}, 32'(ship_count), 32'(cnt_m));
        chk({tag, "_idle"}, 32'(busy), 32'd0);
        chk({tag, "_hold_addr"}, 32'(board_write_addr), 32'(last_addr_m));
        chk({tag, "_hold_data"}, 32'(board_write_data), 32'(last_data_m));
    endtask

    initial begin
        int x;
        int y;
        int n_we;

        rst         = 1'b1;
        enable      = 1'b1;
        mouse_x_pos = 12'd0;
        mouse_y_pos = 12'd0;
        mouse_left  = 1'b0;
        model_reset();

        // Reset state
        repeat (3) @(negedge clk);
        chk("rst_we", 32'(board_write_enable), 32'd0);
        chk("rst_addr", 32'(board_write_addr), 32'd0);
        chk("rst_data", 32'(board_write_data), 32'd0);
        chk("rst_count", 32'(ship_count), 32'd0);
        chk("rst_reject", 32'(reject), 32'd0);
        chk("rst_busy", 32'(busy), 32'd1);
        rst = 1'b0;
        check_clear("clear1");

        // Directed clicks
        click("c_00", 100, 200, 1'b1, 1'b0, 4);
        chk("c_00_addr_k", 32'(board_write_addr), 32'h00);
        chk("c_00_data_k", 32'(board_write_data), 32'h1);
        chk("c_00_cnt_k", 32'(ship_count), 32'd1);
        click("c_00_off", 100, 200, 1'b1, 1'b0, 4);
        chk("c_00_off_data_k", 32'(board_write_data), 32'h0);
        chk("c_00_off_cnt_k", 32'(ship_count), 32'd0);
        click("c_bb", 483, 583, 1'b1, 1'b0, 6);
        chk("c_bb_addr_k", 32'(board_write_addr), 32'hBB);
        chk("c_bb_cnt_k", 32'(ship_count), 32'd1);
        click("out_x", 484, 583, 1'b1, 1'b0, 4);
        click("out_y", 483, 584, 1'b1, 1'b0, 4);
        click("out_lo", 99, 200, 1'b1, 1'b0, 4);
        click("c_02_on", 165, 231, 1'b1, 1'b0, 4);
        chk("c_02_on_addr_k", 32'(board_write_addr), 32'h02);
        chk("c_02_on_cnt_k", 32'(ship_count), 32'd2);
        click("c_02_off", 165, 231, 1'b1, 1'b0, 4);
        chk("c_02_off_data_k", 32'(board_write_data), 32'h0);
        chk("c_02_off_cnt_k", 32'(ship_count), 32'd1);
        click("cap_fill", 132, 200, 1'b1, 1'b0, 4);
        chk("cap_fill_cnt_k", 32'(ship_count), 32'd2);
        click("cap_rej", 196, 200, 1'b1, 1'b0, 4);
        chk("cap_rej_cnt_k", 32'(ship_count), 32'd2);
        click("disabled", 228, 200, 1'b0, 1'b0, 4);
        click("en_drop", 260, 264, 1'b1, 1'b1, 3);

        // Randomized clicks
        for (int i = 0; i < 40; i++) begin
            if ($urandom_range(0, 1) == 1) begin
                x = X_POS + int'($urandom_range(0, 2)) * CELL_SIZE + int'($urandom_range(0, 31));
                y = Y_POS + int'($urandom_range(0, 1)) * CELL_SIZE + int'($urandom_range(0, 31));
            end else begin
                x = int'($urandom_range(60, 520));
                y = int'($urandom_range(160, 620));
            end
            click("rnd", x, y, ($urandom_range(0, 7) != 0), ($urandom_range(0, 3) == 0),
                  int'($urandom_range(2, 20)));
        end

        // Reset mid-DIV: the click in flight must not write, and the sweep restarts
        n_we = 0;
        @(negedge clk);
        mouse_x_pos = 12'd483;
        mouse_y_pos = 12'd583;
        mouse_left  = 1'b1;
        for (int k = 1; k <= 8; k++) begin
            @(negedge clk);
            if (board_write_enable) n_we++;
        end
        chk("middiv_busy", 32'(busy), 32'd1);
        rst        = 1'b1;
        mouse_left = 1'b0;
        repeat (2) begin
            @(negedge clk);
            if (board_write_enable) n_we++;
        end
        chk("middiv_nwe", 32'(n_we), 32'd0);
        chk("middiv_count", 32'(ship_count), 32'd0);
        rst = 1'b0;
        check_clear("clear2");

        // A long hold produces exactly one write
        click("hold", 100, 200, 1'b1, 1'b0, 1000);
        chk("hold_cnt_k", 32'(ship_count), 32'd1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
